// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus scheduler slice.
package rtc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SRC_WR  = 2'd0,
      SRC_RD  = 2'd1,
      SRC_REF = 2'd2
   } src_e;

   localparam logic [7:0] RTC_ADDR_SECONDS     = 8'h21;
   localparam logic [7:0] RTC_ADDR_MINUTES     = 8'h22;
   localparam logic [7:0] RTC_ADDR_HOURS       = 8'h23;
   localparam logic [7:0] REFRESH_BASE_DEFAULT = RTC_ADDR_SECONDS;

endpackage

// File: rtl/rtc_refresh_timer.sv
// Periodic refresh timer: sweep interval counter, pending flag, register
// index within the sweep and the sticky overrun flag.
module rtc_refresh_timer #(
   parameter int REFRESH_CYCLES = 100000,
   parameter int REFRESH_LEN    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       refresh_en_i,
   input  logic       ref_done_i,
   output logic       ref_pending_o,
   output logic [2:0] ref_idx_o,
   output logic       ref_overrun_o
);

   localparam int              CW       = $clog2(REFRESH_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_CYCLES - 1);
   localparam logic [2:0]      IDX_LAST = 3'(REFRESH_LEN - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic [2:0]    idx_q, idx_d;
   logic          overrun_q, overrun_d;

   // Advance the sweep index on each finished refresh read, then let a
   // counter wrap raise a new sweep (restarting the index on overrun).
   always_comb begin
      cnt_d     = cnt_q;
      pending_d = pending_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      if (ref_done_i) begin
         if (idx_q == IDX_LAST) begin
            idx_d     = 3'd0;
            pending_d = 1'b0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
      if (!refresh_en_i) begin
         cnt_d     = '0;
         pending_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d     = '0;
         pending_d = 1'b1;
         if (pending_q) begin
            overrun_d = 1'b1;
            idx_d     = 3'd0;
         end
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Timer state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
         idx_q     <= 3'd0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         overrun_q <= overrun_d;
      end
   end

   assign ref_pending_o = pending_q;
   assign ref_idx_o     = idx_q;
   assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/rtc_bus_sched.sv
// RTC bus scheduler: arbitrates user writes, user reads and refresh reads
// onto the shared bus, starts the owning engine and acks the requester.
module rtc_bus_sched
   import rtc_bus_pkg::*;
#(
   parameter int         REFRESH_CYCLES = 100000,
   parameter logic [7:0] REFRESH_BASE   = REFRESH_BASE_DEFAULT,
   parameter int         REFRESH_LEN    = 3,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ack,
   input  logic       rd_req,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       rd_ack,
   input  logic       refresh_en,
   output logic       ref_valid,
   output logic [7:0] ref_addr,
   output logic [7:0] ref_data,
   output logic [7:0] eng_addr,
   output logic [7:0] eng_wdata,
   output logic       we_start,
   input  logic       we_done,
   output logic       re_start,
   input  logic       re_done,
   input  logic [7:0] re_data,
   output logic       sel_rd,
   output logic       busy,
   output logic       timeout_err,
   output logic       ref_overrun
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e     state_q, state_d;
   src_e       src_q, src_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       sel_rd_q, sel_rd_d;
   logic [7:0] tcnt_q, tcnt_d;
   logic       last_wr_q, last_wr_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic [7:0] ref_addr_q, ref_addr_d;
   logic [7:0] ref_data_q, ref_data_d;
   logic       ref_pending;
   logic [2:0] ref_idx;
   logic       eng_done;
   logic       timeout_hit;
   logic [7:0] cap_data;

   rtc_refresh_timer #(
      .REFRESH_CYCLES (REFRESH_CYCLES),
      .REFRESH_LEN    (REFRESH_LEN)
   ) u_timer (
      .clk           (clk),
      .rst           (rst),
      .refresh_en_i  (refresh_en),
      .ref_done_i    (ref_valid),
      .ref_pending_o (ref_pending),
      .ref_idx_o     (ref_idx),
      .ref_overrun_o (ref_overrun)
   );

   // Next-state logic: alternate fairly between simultaneous user requests,
   // give refresh the leftover slots, and bound every engine wait.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      sel_rd_d    = sel_rd_q;
      tcnt_d      = tcnt_q;
      last_wr_d   = last_wr_q;
      rd_data_d   = rd_data_q;
      ref_addr_d  = ref_addr_q;
      ref_data_d  = ref_data_q;
      timeout_hit = 1'b0;
      cap_data    = 8'h00;
      eng_done    = (src_q == SRC_WR) ? we_done : re_done;
      case (state_q)
         IDLE: begin
            if (wr_req && (!rd_req || !last_wr_q)) begin
               src_d     = SRC_WR;
               addr_d    = wr_addr;
               wdata_d   = wr_data;
               sel_rd_d  = 1'b0;
               last_wr_d = 1'b1;
               state_d   = START;
            end else if (rd_req) begin
               src_d     = SRC_RD;
               addr_d    = rd_addr;
               sel_rd_d  = 1'b1;
               last_wr_d = 1'b0;
               state_d   = START;
            end else if (ref_pending) begin
               src_d    = SRC_REF;
               addr_d   = REFRESH_BASE + {5'd0, ref_idx};
               sel_rd_d = 1'b1;
               state_d  = START;
            end
         end
         START: begin
            tcnt_d  = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (eng_done || (tcnt_q == TIMEOUT_LAST)) begin
               timeout_hit = !eng_done;
               cap_data    = eng_done ? re_data : 8'h00;
               if (src_q == SRC_RD) begin
                  rd_data_d = cap_data;
               end
               if (src_q == SRC_REF) begin
                  ref_data_d = cap_data;
                  ref_addr_d = addr_q;
               end
               state_d = ACK;
            end else begin
               tcnt_d = tcnt_q + 8'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scheduler registers; reset drops any transaction in flight without an ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         src_q      <= SRC_WR;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         sel_rd_q   <= 1'b0;
         tcnt_q     <= 8'd0;
         last_wr_q  <= 1'b0;
         rd_data_q  <= 8'h00;
         ref_addr_q <= 8'h00;
         ref_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         sel_rd_q   <= sel_rd_d;
         tcnt_q     <= tcnt_d;
         last_wr_q  <= last_wr_d;
         rd_data_q  <= rd_data_d;
         ref_addr_q <= ref_addr_d;
         ref_data_q <= ref_data_d;
      end
   end

   assign we_start    = (state_q == START) && (src_q == SRC_WR);
   assign re_start    = (state_q == START) && (src_q != SRC_WR);
   assign wr_ack      = (state_q == ACK) && (src_q == SRC_WR);
   assign rd_ack      = (state_q == ACK) && (src_q == SRC_RD);
   assign ref_valid   = (state_q == ACK) && (src_q == SRC_REF);
   assign busy        = (state_q != IDLE);
   assign timeout_err = timeout_hit;
   assign eng_addr    = addr_q;
   assign eng_wdata   = wdata_q;
   assign sel_rd      = sel_rd_q;
   assign rd_data     = rd_data_q;
   assign ref_addr    = ref_addr_q;
   assign ref_data    = ref_data_q;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Testbench for rtc_bus_sched: an RTC memory model predicts every ack,
// an engine emulator answers start pulses and a monitor scores the acks.
module tb_rtc_bus_sched;

   localparam int         RC  = 32;
   localparam int         RL  = 3;
   localparam logic [7:0] RB  = 8'h21;
   localparam int         TMO = 8;

   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_REF = 2;

   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] data;
      int         delay;
      bit         tmo;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       wrReq, rdReq, refreshEn;
   logic [7:0] wrAddr, wrData, rdAddr;
   logic       wrAck, rdAck, refValid;
   logic [7:0] rdData, refAddr, refData, engAddr, engWdata;
   logic       weStart, reStart, weDone, reDone;
   logic [7:0] reData;
   logic       selRd, busy, timeoutErr, refOverrun;

   exp_t       expQ[$];
   logic [7:0] modelMem [0:255];
   logic [7:0] emulMem  [0:255];
   bit         modelLastWr;
   bit         resetTest;
   bit         timeoutSeen;
   int         checkCount;
   int         errorCount;

   rtc_bus_sched #(
      .REFRESH_CYCLES (RC),
      .REFRESH_BASE   (RB),
      .REFRESH_LEN    (RL),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_req      (wrReq),
      .wr_addr     (wrAddr),
      .wr_data     (wrData),
      .wr_ack      (wrAck),
      .rd_req      (rdReq),
      .rd_addr     (rdAddr),
      .rd_data     (rdData),
      .rd_ack      (rdAck),
      .refresh_en  (refreshEn),
      .ref_valid   (refValid),
      .ref_addr    (refAddr),
      .ref_data    (refData),
      .eng_addr    (engAddr),
      .eng_wdata   (engWdata),
      .we_start    (weStart),
      .we_done     (weDone),
      .re_start    (reStart),
      .re_done     (reDone),
      .re_data     (reData),
      .sel_rd      (selRd),
      .busy        (busy),
      .timeout_err (timeoutErr),
      .ref_overrun (refOverrun)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [63:0] outVec();
      logic [63:0] v;
      v = '0;
      v[48:0] = {wrAck, rdData, rdAck, refValid, refAddr, refData, engAddr, engWdata,
                 weStart, reStart, selRd, busy, timeoutErr, refOverrun};
      return v;
   endfunction

   function automatic logic [2:0] kindOneHot(input int kind);
      if (kind == K_WR) return 3'b100;
      if (kind == K_RD) return 3'b010;
      return 3'b001;
   endfunction

   // Reference model: the engine stays silent past the limit => timeout,
   // a timed-out write changes nothing and a timed-out read returns zero.
   task automatic pushTxn(input int kind, input logic [7:0] addr, input logic [7:0] wdata, input int delay);
      exp_t e;
      e.kind  = kind;
      e.addr  = addr;
      e.wdata = wdata;
      e.delay = delay;
      e.tmo   = (delay > TMO);
      if (kind == K_WR) begin
         e.data = 8'h00;
         if (!e.tmo) modelMem[addr] = wdata;
      end else begin
         e.data = e.tmo ? 8'h00 : modelMem[addr];
      end
      expQ.push_back(e);
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("idle_before_request", busy, 0);
   endtask

   task automatic applyStimulus(input bit doWr, input bit doRd, input logic [7:0] wa, input logic [7:0] wd,
                                input logic [7:0] ra, input int wrDelay, input int rdDelay);
      int guard;
      bit wrFirst;
      waitIdle();
      wrFirst = doWr && (!doRd || !modelLastWr);
      if (wrFirst) begin
         pushTxn(K_WR, wa, wd, wrDelay);
         if (doRd) pushTxn(K_RD, ra, 8'h00, rdDelay);
      end else begin
         pushTxn(K_RD, ra, 8'h00, rdDelay);
         if (doWr) pushTxn(K_WR, wa, wd, wrDelay);
      end
      modelLastWr = (doWr && doRd) ? !wrFirst : doWr;
      wrAddr = wa;
      wrData = wd;
      rdAddr = ra;
      wrReq  = doWr;
      rdReq  = doRd;
      @(negedge clk);
      checkOutput("start_latency", weStart | reStart, 1);
      guard = 0;
      while ((wrReq || rdReq) && guard < 200) begin
         if (wrAck) wrReq = 1'b0;
         if (rdAck) rdReq = 1'b0;
         if (wrReq || rdReq) begin
            @(negedge clk);
            guard++;
         end
      end
      checkOutput("ack_wait_bound", {wrReq, rdReq}, 0);
      wrReq = 1'b0;
      rdReq = 1'b0;
   endtask

   // Engine emulator: answers each start after the delay the stimulus chose,
   // pulses the other engine's done as a distraction and checks bus steering.
   initial begin : engine
      exp_t cur;
      int   tmoAt;
      weDone = 1'b0;
      reDone = 1'b0;
      reData = 8'h00;
      forever begin
         @(negedge clk);
         if (rst && (weStart || reStart)) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_start", expQ.size(), 1);
            end else begin
               cur = expQ[0];
               checkOutput("start_kind", {weStart, reStart}, (cur.kind == K_WR) ? 2'b10 : 2'b01);
               checkOutput("eng_addr", engAddr, cur.addr);
               if (cur.kind == K_WR) checkOutput("eng_wdata", engWdata, cur.wdata);
               checkOutput("sel_rd_start", selRd, cur.kind != K_WR);
               if (!cur.tmo) begin
                  for (int i = 1; i <= cur.delay; i++) begin
                     @(negedge clk);
                     reData = 8'($urandom);
                     if (cur.kind == K_WR) reDone = (i == 1) && (cur.delay >= 2);
                     else                  weDone = (i == 1) && (cur.delay >= 2);
                     if (i == cur.delay) begin
                        if (cur.kind == K_WR) begin
                           weDone = 1'b1;
                        end else begin
                           reDone = 1'b1;
                           reData = emulMem[cur.addr];
                        end
                     end
                  end
                  @(negedge clk);
                  weDone = 1'b0;
                  reDone = 1'b0;
                  reData = 8'($urandom);
                  if (cur.kind == K_WR) begin
                     checkOutput("wr_ack_latency", wrAck, 1);
                     emulMem[cur.addr] = cur.wdata;
                  end else if (cur.kind == K_RD) begin
                     checkOutput("rd_ack_latency", rdAck, 1);
                  end else begin
                     checkOutput("ref_ack_latency", refValid, 1);
                  end
               end else begin
                  tmoAt = 0;
                  for (int i = 1; i <= TMO; i++) begin
                     @(negedge clk);
                     reData = 8'($urandom);
                     if (cur.kind == K_WR) reDone = (i == 1);
                     else                  weDone = (i == 1);
                     if (timeoutErr && tmoAt == 0) tmoAt = i;
                  end
                  weDone = 1'b0;
                  reDone = 1'b0;
                  if (!resetTest) checkOutput("timeout_cycle", tmoAt, TMO);
               end
            end
         end
      end
   end

   // Monitor: every ack pops the oldest expectation and is scored against it.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         timeoutSeen = 1'b0;
      end else begin
         if (timeoutErr) timeoutSeen = 1'b1;
         if (wrAck || rdAck || refValid) begin
            checkOutput("ack_onehot", int'(wrAck) + int'(rdAck) + int'(refValid), 1);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_ack", expQ.size(), 1);
            end else begin
               e = expQ.pop_front();
               checkOutput("ack_kind", {wrAck, rdAck, refValid}, kindOneHot(e.kind));
               if (e.kind == K_RD) checkOutput("rd_data", rdData, e.data);
               if (e.kind == K_REF) begin
                  checkOutput("ref_addr", refAddr, e.addr);
                  checkOutput("ref_data", refData, e.data);
               end
               checkOutput("timeout_flag", timeoutSeen, e.tmo);
               timeoutSeen = 1'b0;
            end
         end
      end
   end

   // Main stimulus sequence.
   initial begin : stimulus
      int ackCount;
      int guard;
      int stray;
      int mode;
      int d1, d2;
      logic [7:0] wa, wd, ra, v;
      checkCount  = 0;
      errorCount  = 0;
      resetTest   = 1'b0;
      modelLastWr = 1'b0;
      rst       = 1'b0;
      wrReq     = 1'b0;
      rdReq     = 1'b0;
      refreshEn = 1'b0;
      wrAddr    = 8'h00;
      wrData    = 8'h00;
      rdAddr    = 8'h00;
      for (int i = 0; i < 256; i++) begin
         v = 8'($urandom);
         modelMem[i] = v;
         emulMem[i]  = v;
      end
      #1;
      checkOutput("reset_outputs", outVec(), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] held write+read requests alternate W,R,W,R");
      waitIdle();
      wa = 8'h40;
      wd = 8'hC3;
      ra = 8'h40;
      for (int k = 0; k < 2; k++) begin
         pushTxn(K_WR, wa, wd, 2);
         pushTxn(K_RD, ra, 8'h00, 3);
      end
      modelLastWr = 1'b0;
      wrAddr = wa;
      wrData = wd;
      rdAddr = ra;
      wrReq  = 1'b1;
      rdReq  = 1'b1;
      ackCount = 0;
      guard    = 0;
      while (ackCount < 4 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (wrAck || rdAck) begin
            ackCount++;
            if (ackCount == 4) begin
               wrReq = 1'b0;
               rdReq = 1'b0;
            end
         end
      end
      checkOutput("alternation_ack_count", ackCount, 4);
      wrReq = 1'b0;
      rdReq = 1'b0;

      $display("[TB] directed write/read and timeouts");
      applyStimulus(1, 0, 8'h0B, 8'h5A, 8'h00, TMO, 1);
      checkOutput("sel_rd_write_idle", selRd, 0);
      applyStimulus(1, 0, 8'h0C, 8'h80, 8'h00, 1, 1);
      applyStimulus(0, 1, 8'h00, 8'h00, 8'h0C, 1, 4);
      checkOutput("sel_rd_read_idle", selRd, 1);
      applyStimulus(0, 1, 8'h00, 8'h00, 8'h0B, 1, 2);
      applyStimulus(0, 1, 8'h00, 8'h00, 8'h0C, 1, TMO + 1);
      applyStimulus(1, 0, 8'h0C, 8'h11, 8'h00, TMO + 1, 1);
      applyStimulus(0, 1, 8'h00, 8'h00, 8'h0C, 1, 1);

      $display("[TB] randomized user traffic");
      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(1, 3);
         d1 = ($urandom_range(0, 9) == 0) ? TMO + 1 : (($urandom_range(0, 9) == 0) ? TMO : $urandom_range(1, 4));
         d2 = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(1, 4);
         wa = 8'($urandom_range(0, 15));
         wd = 8'($urandom);
         ra = 8'($urandom_range(0, 15));
         applyStimulus(mode[0], mode[1], wa, wd, ra, d1, d2);
      end

      $display("[TB] refresh sweeps");
      waitIdle();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < RL; i++) begin
            pushTxn(K_REF, RB + 8'(i), 8'h00, $urandom_range(1, 4));
         end
      end
      refreshEn = 1'b1;
      guard = 0;
      while (expQ.size() > 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      refreshEn = 1'b0;
      checkOutput("refresh_drain", expQ.size(), 0);
      checkOutput("ref_overrun", refOverrun, 0);
      expQ.delete();

      $display("[TB] reset in the middle of a read");
      waitIdle();
      resetTest = 1'b1;
      pushTxn(K_RD, 8'h0C, 8'h00, TMO + 1);
      rdAddr = 8'h0C;
      rdReq  = 1'b1;
      @(negedge clk);
      checkOutput("reset_txn_start", reStart, 1);
      rdReq = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1 checkOutput("reset_async_outputs", outVec(), 0);
      expQ.delete();
      modelLastWr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         stray += int'(wrAck) + int'(rdAck) + int'(refValid);
      end
      checkOutput("no_stray_ack", stray, 0);
      checkOutput("idle_after_reset", busy, 0);
      resetTest = 1'b0;

      $display("[TB] write wins first tie after reset");
      applyStimulus(1, 1, 8'h05, 8'h66, 8'h05, 2, 2);
      repeat (4) @(negedge clk);
      checkOutput("queue_empty_at_end", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/rtc_bus_sched.md
Name: rtc_bus_sched

Overview:
- Scheduler and arbiter for the multiplexed RTC bus shared by the write-cycle engine and the read-cycle engine.
- Accepts user write requests, user read requests and internally generated periodic refresh reads (time/date registers).
- Issues start pulses to the owning engine and steers the bus mux to that engine.
- Waits for the engine's end flag, with a timeout, then returns an ack and data to the requester.

Parameters:
- REFRESH_CYCLES, 100000: clk cycles between refresh sweeps; min 16.
- REFRESH_BASE, 8'h21: first RTC register address read in a refresh sweep.
- REFRESH_LEN, 3: number of consecutive registers per sweep; range 1..8.
- TIMEOUT_CYCLES, 255: max cycles in WAIT before abort; range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wr_req  in  1  user write request, level.
- wr_addr  in  8  write address, sampled at grant.
- wr_data  in  8  write data, sampled at grant.
- wr_ack  out  1  one-cycle pulse: write finished or aborted.
- rd_req  in  1  user read request, level.
- rd_addr  in  8  read address, sampled at grant.
- rd_data  out  8  read result, valid while rd_ack=1.
- rd_ack  out  1  one-cycle pulse: read finished or aborted.
- refresh_en  in  1  enables periodic refresh.
- ref_valid  out  1  one-cycle pulse: refresh register read.
- ref_addr  out  8  address of ref_data.
- ref_data  out  8  refresh read result.
- eng_addr  out  8  address to engines.
- eng_wdata  out  8  write data to write engine.
- we_start  out  1  write engine start pulse.
- we_done  in  1  write engine end flag.
- re_start  out  1  read engine start pulse.
- re_done  in  1  read engine end flag.
- re_data  in  8  read engine captured data, valid with re_done.
- sel_rd  out  1  bus mux select: 0 = write engine, 1 = read engine.
- busy  out  1  state != IDLE.
- timeout_err  out  1  one-cycle pulse on engine timeout.
- ref_overrun  out  1  sticky: new sweep due before previous finished; cleared only by reset.

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; refresh counter 0; ref_pending 0; ref_idx 0; last_was_wr 0.
- States: IDLE, START, WAIT, ACK.
- IDLE grant priority, evaluated in one cycle:
  - If both wr_req and rd_req are high, alternate: write first after reset, then whichever was not served last (last_was_wr).
  - Otherwise the sole pending user request wins.
  - ref_pending is granted only when neither user request is high.
- Grant: latch source (WR/RD/REF), eng_addr, eng_wdata (WR only); go to START.
- START (1 cycle): we_start=1 for WR, else re_start=1. sel_rd=1 for RD/REF. Clear timeout counter. Go to WAIT.
- WAIT:
  - Hold eng_addr, eng_wdata, sel_rd.
  - done from selected engine → capture re_data, go to ACK.
  - Otherwise counter++. At TIMEOUT_CYCLES: timeout_err=1 that cycle, captured data=8'h00, go to ACK.
  - Done arriving on the same cycle as the limit wins; no error.
  - The non-selected engine's done is ignored.
- ACK (1 cycle):
  - WR: wr_ack=1.
  - RD: rd_ack=1, rd_data=captured.
  - REF: ref_valid=1, ref_addr=REFRESH_BASE+ref_idx, ref_data=captured. Then ref_idx++; if ref_idx was REFRESH_LEN-1, set ref_idx=0 and clear ref_pending.
  - Always → IDLE.
- rd_data/ref_data/ref_addr hold last value outside ack; sel_rd holds last value in IDLE.
- Latency: request high in IDLE at cycle N → start pulse at N+1. Ack at the cycle after done. Minimum IDLE-to-IDLE is 4 cycles.
- Requesters must drop req the cycle after ack; a req still high in IDLE is a new request.
- Refresh counter:
  - refresh_en=1: counts 0..REFRESH_CYCLES-1 and wraps. On wrap, set ref_pending. If ref_pending was already 1, set ref_overrun and restart ref_idx at 0.
  - refresh_en=0: counter held at 0 and ref_pending cleared. An in-flight REF transaction completes normally.
- Address arithmetic is 8-bit, wrapping modulo 256.
- Reset mid-transaction aborts immediately, with no ack.

Decomposition:
- Shared package rtc_bus_pkg: state encoding (IDLE=2'd0, START=2'd1, WAIT=2'd2, ACK=2'd3), source encoding (SRC_WR, SRC_RD, SRC_REF), RTC address constants including the default REFRESH_BASE.
- One sub-module: rtc_refresh_timer, containing the refresh counter, ref_pending, ref_idx and ref_overrun.
- Everything else stays in rtc_bus_sched.

Test Plan:
- Write 8'h5A to 8'h0B, we_done 10 cycles after we_start → we_start one cycle after req, eng_addr=8'h0B, eng_wdata=8'h5A, sel_rd=0, wr_ack one cycle after done.
- Read 8'h0C with re_data=8'h80 at re_done → re_start pulse, sel_rd=1, rd_ack with rd_data=8'h80.
- wr_req and rd_req high together, reasserted after each ack → order W, R, W, R.
- REFRESH_CYCLES=16, REFRESH_LEN=3, no user traffic → three ref_valid pulses with ref_addr 8'h21, 8'h22, 8'h23 after each wrap; ref_overrun stays 0.
- re_done never asserted, TIMEOUT_CYCLES=8 → timeout_err pulse 8 cycles into WAIT, rd_ack with rd_data=8'h00, back to IDLE.
- rst=0 during WAIT → all outputs 0 asynchronously; after release, IDLE with no stray ack.
